// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes.
// Optional performance counters enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       pc_src,
  output logic       ext_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       instr_done
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [15:0] cycle_count,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_R   = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_BEQ = 2'b11
  } opcode_t;

  state_t  r_state;
  state_t  w_next;
  state_t  w_end_next;
  opcode_t r_opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= OP_R;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= opcode_t'(opcode);
    end
  end

  // Where a finished instruction goes; run is only honoured here and in IDLE.
  assign w_end_next = run ? S_FETCH : S_IDLE;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        case (r_opcode)
          OP_R:          w_next = S_WB;
          OP_LW, OP_SW:  w_next = S_MEM;
          default:       w_next = w_end_next;
        endcase
      end
      S_MEM: begin
        if (mem_ready) w_next = (r_opcode == OP_LW) ? S_WB : w_end_next;
      end
      S_WB:     w_next = w_end_next;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    pc_src     = 1'b0;
    ext_op     = 1'b0;
    alu_src_b  = '0;
    alu_op     = '0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        case (r_opcode)
          OP_R:   alu_op = 2'b10;
          OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
          end
          default: begin
            alu_op     = 2'b01;
            pc_src     = 1'b1;
            pc_write   = zero;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (r_opcode == OP_LW) begin
          mem_read = 1'b1;
        end else begin
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        if (r_opcode == OP_LW) mem_to_reg = 1'b1;
        else                   reg_dst    = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [15:0] r_cycle_count;
  logic [15:0] r_instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state != S_IDLE) r_cycle_count <= r_cycle_count + 16'd1;
      if (instr_done)        r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port run  input  1  enable instruction sequencing; sampled in IDLE and at instruction end.
REQ-004 SHALL have port opcode  input  2  IR opcode field (00 R-type, 01 LW, 10 SW, 11 BEQ), valid from DECODE onward.
REQ-005 SHALL have port zero  input  1  ALU zero flag, consumed in EXEC of BEQ.
REQ-006 SHALL have port mem_ready  input  1  memory handshake, access completes in cycle it is high.
REQ-007 SHALL have outputs pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, pc_src, ext_op  output  1 each  datapath strobes/selects.
REQ-008 SHALL have outputs alu_src_b  output  2  (00 reg B, 01 const 1, 10 ext imm, 11 ext imm branch offset); alu_op  output  2  (00 add, 01 sub, 10 funct).
REQ-009 SHALL have outputs state  output  3  current state code; instr_done  output  1  one-cycle pulse in final cycle of every instruction.

Function
REQ-010 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6,7 SHALL go to IDLE next cycle with all outputs 0.
REQ-011 SHALL drive all outputs combinationally from state, latched opcode, zero, mem_ready; any output not listed for a state SHALL be 0.
REQ-012 IDLE: -> FETCH when run=1, else stay.
REQ-013 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00; stay while mem_ready=0; when mem_ready=1, ir_write=1, pc_write=1, -> DECODE.
REQ-014 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_op=1; opcode SHALL be registered internally this cycle; -> EXEC.
REQ-015 EXEC R-type: alu_src_a=1, alu_src_b=00, alu_op=10; -> WB.
REQ-016 EXEC LW/SW: alu_src_a=1, alu_src_b=10, alu_op=00, ext_op=1; -> MEM.
REQ-017 EXEC BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero, instr_done=1; instruction ends.
REQ-018 MEM: i_or_d=1, mem_read=1 for LW, mem_write=1 for SW, held until mem_ready=1; LW -> WB on ready; SW instr_done=1 on ready, instruction ends.
REQ-019 WB: reg_write=1, instr_done=1; R-type reg_dst=1, mem_to_reg=0; LW reg_dst=0, mem_to_reg=1; instruction ends.
REQ-020 At instruction end next state SHALL be FETCH if run=1, else IDLE; run deassert mid-instruction SHALL NOT abort it.
REQ-021 Latency with mem_ready tied 1: BEQ 3, R-type 4, SW 4, LW 5 cycles; each wait cycle on mem_ready adds exactly 1.
REQ-022 mem_read and mem_write SHALL never be high in the same cycle; reg_write and pc_write SHALL never be high in the same cycle.

Reset
REQ-023 rst_n=0 SHALL force state=IDLE and latched opcode=00 immediately, regardless of clk, including mid-instruction or mid-memory-wait.
REQ-024 During reset all outputs SHALL be 0; first FETCH SHALL occur the first clk edge after rst_n=1 with run=1.

Configuration
REQ-025 Macro MULTICYCLE_PERF_CNT_EN SHALL, when defined, add outputs cycle_count  output  16 and instr_count  output  16.
REQ-026 With macro: cycle_count SHALL increment each cycle state!=IDLE; instr_count SHALL increment on each instr_done; both wrap FFFF->0000, clear on reset.
REQ-027 Without macro: ports and counter registers SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, run=1, mem_ready=1, opcode=00 -> state sequence 0,1,2,3,5,1; reg_write=1, reg_dst=1 in WB; instr_done at cycle 4.
REQ-029 opcode=01, mem_ready low 2 cycles in MEM -> MEM held 3 cycles with mem_read=1, i_or_d=1; WB mem_to_reg=1; total 7 cycles.
REQ-030 opcode=11, zero=1 then zero=0 -> pc_write=1 with pc_src=1 in EXEC first case, pc_write=0 second; 3 cycles each.
REQ-031 opcode=10, run dropped in EXEC -> MEM with mem_write=1, instr_done, then IDLE; no further FETCH.
REQ-032 rst_n pulsed low asynchronously during FETCH wait -> state=0, all outputs 0 before next clk edge.
REQ-033 With MULTICYCLE_PERF_CNT_EN, counters preloaded near FFFF via run of instructions -> wrap to 0000, instr_count equals instr_done pulse count mod 65536.
